// File: rtl/ddr_ctrl_pkg.sv
// Shared definitions for the DDR command issuer and the bank timing model:
// controller state encoding, one-hot command encodings and default timings.
package ddr_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACT_WAIT,
      S_CAS_WAIT,
      S_PRE_WAIT,
      S_REF_PRE_WAIT,
      S_REF_WAIT
   } state_t;

   localparam int CMD_W = 8;

   // Bit positions inside the one-hot command vector
   localparam int I_ACT = 0;
   localparam int I_RD  = 1;
   localparam int I_WR  = 2;
   localparam int I_RDA = 3;
   localparam int I_WRA = 4;
   localparam int I_PR  = 5;
   localparam int I_PRA = 6;
   localparam int I_REF = 7;

   localparam logic [CMD_W-1:0] C_ACT = 8'b0000_0001;
   localparam logic [CMD_W-1:0] C_RD  = 8'b0000_0010;
   localparam logic [CMD_W-1:0] C_WR  = 8'b0000_0100;
   localparam logic [CMD_W-1:0] C_RDA = 8'b0000_1000;
   localparam logic [CMD_W-1:0] C_WRA = 8'b0001_0000;
   localparam logic [CMD_W-1:0] C_PR  = 8'b0010_0000;
   localparam logic [CMD_W-1:0] C_PRA = 8'b0100_0000;
   localparam logic [CMD_W-1:0] C_REF = 8'b1000_0000;

   // Default timings, identical to the ones the bank timing model enforces
   localparam int DEF_TRCD  = 22;
   localparam int DEF_TCL   = 14;
   localparam int DEF_TRP   = 20;
   localparam int DEF_TRFC  = 243;
   localparam int DEF_TREFI = 7800;

   // Column command for a request; auto-precharge variants in closed-page mode
   function automatic logic [CMD_W-1:0] col_cmd(input logic closed, input logic write);
      if (closed) return write ? C_WRA : C_RDA;
      return write ? C_WR : C_RD;
   endfunction

endpackage

// File: rtl/ddr_bank_table.sv
// Per-bank open flag and open-row register. Lookup outputs are combinational
// on the presented bank/row; updates take effect at the next clock edge.
module ddr_bank_table
   import ddr_ctrl_pkg::*;
#(
   parameter int NBANKS = 4,
   parameter int ROWW   = 14,
   localparam int BW    = $clog2(NBANKS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            set,
   input  logic            clear,
   input  logic            clear_all,
   input  logic [BW-1:0]   bank,
   input  logic [ROWW-1:0] row,
   output logic            hit,
   output logic            open,
   output logic            any_open
);

   logic [NBANKS-1:0] flags;
   logic [ROWW-1:0]   rows [NBANKS];

   // Open flags: set by ACT, cleared by PR / auto-precharge, all cleared by PRA
   always_ff @(posedge clk) begin
      if (rst) begin
         flags <= '0;
      end else if (clear_all) begin
         flags <= '0;
      end else begin
         if (set)   flags[bank] <= 1'b1;
         if (clear) flags[bank] <= 1'b0;
      end
   end

   // Row register only matters while the flag is set, so it needs no reset
   always_ff @(posedge clk) begin
      if (set) rows[bank] <= row;
   end

   assign open     = flags[bank];
   assign hit      = flags[bank] && (rows[bank] == row);
   assign any_open = |flags;

endmodule

// File: rtl/ddr_cmd_issuer.sv
// DDR command issuer: accepts read/write requests, tracks open rows and issues
// timed ACT/RD/WR/PR/PRA/REF pulses plus periodic refresh.
// Build option: define DDR_CLOSED_PAGE_EN for closed-page operation (RDA/WRA
// with auto-precharge, every request activates its row).
module ddr_cmd_issuer
   import ddr_ctrl_pkg::*;
#(
   parameter int NBANKS = 4,
   parameter int ROWW   = 14,
   parameter int COLW   = 10,
   parameter int TRCD   = DEF_TRCD,
   parameter int TCL    = DEF_TCL,
   parameter int TRP    = DEF_TRP,
   parameter int TRFC   = DEF_TRFC,
   parameter int TREFI  = DEF_TREFI,
   localparam int BW    = $clog2(NBANKS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [BW-1:0]   req_bank,
   input  logic [ROWW-1:0] req_row,
   input  logic [COLW-1:0] req_col,
   output logic            ACT,
   output logic            RD,
   output logic            WR,
   output logic            RDA,
   output logic            WRA,
   output logic            PR,
   output logic            PRA,
   output logic            REF,
   output logic [BW-1:0]   cmd_bank,
   output logic [ROWW-1:0] cmd_addr,
   output logic            done,
   output logic            busy
);

`ifdef DDR_CLOSED_PAGE_EN
   localparam bit CLOSED_PAGE = 1'b1;
`else
   localparam bit CLOSED_PAGE = 1'b0;
`endif

   state_t           state, state_nx;
   logic [7:0]       cnt, cnt_nx;
   logic [15:0]      ref_cnt;
   logic             ref_pending, ref_clr;
   logic [CMD_W-1:0] cmd_q, cmd_nx;
   logic [BW-1:0]    bank_nx;
   logic [ROWW-1:0]  addr_nx;
   logic             done_nx;
   logic             accept;

   logic             lat_write;
   logic [BW-1:0]    lat_bank;
   logic [ROWW-1:0]  lat_row;
   logic [COLW-1:0]  lat_col;

   logic             tbl_hit, tbl_open, tbl_any_open;
   logic [BW-1:0]    tbl_bank;
   logic [ROWW-1:0]  tbl_row;

   assign req_ready = (state == S_IDLE) && !ref_pending && !rst;
   assign accept    = req_valid && req_ready;
   assign busy      = (state != S_IDLE);

   // In IDLE the table looks at the incoming request, otherwise at the latched one
   assign tbl_bank = (state == S_IDLE) ? req_bank : lat_bank;
   assign tbl_row  = (state == S_IDLE) ? req_row  : lat_row;

   ddr_bank_table #(
      .NBANKS (NBANKS),
      .ROWW   (ROWW)
   ) u_table (
      .clk       (clk),
      .rst       (rst),
      .set       (cmd_nx[I_ACT]),
      .clear     (cmd_nx[I_PR] | cmd_nx[I_RDA] | cmd_nx[I_WRA]),
      .clear_all (cmd_nx[I_PRA]),
      .bank      (tbl_bank),
      .row       (tbl_row),
      .hit       (tbl_hit),
      .open      (tbl_open),
      .any_open  (tbl_any_open)
   );

   // Next-state, next-command and timer reload decisions
   always_comb begin
      state_nx = state;
      cnt_nx   = (cnt != 8'd0) ? cnt - 8'd1 : 8'd0;
      cmd_nx   = '0;
      bank_nx  = '0;
      addr_nx  = '0;
      done_nx  = 1'b0;
      ref_clr  = 1'b0;
      case (state)
         S_IDLE: begin
            if (ref_pending) begin
               if (tbl_any_open) begin
                  cmd_nx   = C_PRA;
                  state_nx = S_REF_PRE_WAIT;
                  cnt_nx   = 8'(TRP);
               end else begin
                  cmd_nx   = C_REF;
                  state_nx = S_REF_WAIT;
                  cnt_nx   = 8'(TRFC);
               end
            end else if (accept) begin
               bank_nx = req_bank;
               if (CLOSED_PAGE || !tbl_open) begin
                  cmd_nx   = C_ACT;
                  addr_nx  = req_row;
                  state_nx = S_ACT_WAIT;
                  cnt_nx   = 8'(TRCD);
               end else if (tbl_hit) begin
                  cmd_nx   = col_cmd(CLOSED_PAGE, req_write);
                  addr_nx  = ROWW'(req_col);
                  state_nx = S_CAS_WAIT;
                  cnt_nx   = 8'(TCL);
               end else begin
                  cmd_nx   = C_PR;
                  state_nx = S_PRE_WAIT;
                  cnt_nx   = 8'(TRP);
               end
            end
         end
         S_ACT_WAIT: begin
            if (cnt == 8'd1) begin
               cmd_nx   = col_cmd(CLOSED_PAGE, lat_write);
               bank_nx  = lat_bank;
               addr_nx  = ROWW'(lat_col);
               state_nx = S_CAS_WAIT;
               cnt_nx   = 8'(TCL);
            end
         end
         S_CAS_WAIT: begin
            // done is raised after TCL; the cycle it is visible is the last one here
            if (cnt == 8'd1) done_nx = 1'b1;
            if (done) begin
               if (CLOSED_PAGE) begin
                  state_nx = S_PRE_WAIT;
                  cnt_nx   = 8'(TRP);
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
         S_PRE_WAIT: begin
            if (cnt == 8'd1) begin
               if (CLOSED_PAGE) begin
                  state_nx = S_IDLE;
               end else begin
                  cmd_nx   = C_ACT;
                  bank_nx  = lat_bank;
                  addr_nx  = lat_row;
                  state_nx = S_ACT_WAIT;
                  cnt_nx   = 8'(TRCD);
               end
            end
         end
         S_REF_PRE_WAIT: begin
            if (cnt == 8'd1) begin
               cmd_nx   = C_REF;
               state_nx = S_REF_WAIT;
               cnt_nx   = 8'(TRFC);
            end
         end
         S_REF_WAIT: begin
            if (cnt == 8'd1) begin
               ref_clr  = 1'b1;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State, wait timer and registered command outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= 8'd0;
         cmd_q    <= '0;
         cmd_bank <= '0;
         cmd_addr <= '0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         cmd_q    <= cmd_nx;
         cmd_bank <= bank_nx;
         cmd_addr <= addr_nx;
         done     <= done_nx;
      end
   end

   // Request fields captured on accept; state reset is what drops a request
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_write <= req_write;
         lat_bank  <= req_bank;
         lat_row   <= req_row;
         lat_col   <= req_col;
      end
   end

   // Refresh interval timer; a new expiry wins over a same-cycle clear
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_cnt     <= 16'(TREFI);
         ref_pending <= 1'b0;
      end else begin
         if (ref_cnt == 16'd1) ref_cnt <= 16'(TREFI);
         else                  ref_cnt <= ref_cnt - 16'd1;
         if (ref_clr)           ref_pending <= 1'b0;
         if (ref_cnt == 16'd1)  ref_pending <= 1'b1;
      end
   end

   // RDA/WRA encodings are only ever selected in closed-page builds
   assign ACT = cmd_q[I_ACT];
   assign RD  = cmd_q[I_RD];
   assign WR  = cmd_q[I_WR];
   assign RDA = cmd_q[I_RDA];
   assign WRA = cmd_q[I_WRA];
   assign PR  = cmd_q[I_PR];
   assign PRA = cmd_q[I_PRA];
   assign REF = cmd_q[I_REF];

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Self-checking bench for ddr_cmd_issuer. A transaction-level model schedules
// the expected command/done timeline per request and per refresh; every cycle
// the DUT outputs are compared against that timeline.
module tb_ddr_cmd_issuer;

   localparam int T_RCD  = 22;
   localparam int T_CL   = 14;
   localparam int T_RP   = 20;
   localparam int T_RFC  = 243;
   localparam int T_REFI = 400;

`ifdef DDR_CLOSED_PAGE_EN
   localparam bit CLOSED = 1'b1;
`else
   localparam bit CLOSED = 1'b0;
`endif

   // Bench-side packing of the command pins: {ACT,RD,WR,RDA,WRA,PR,PRA,REF}
   localparam logic [7:0] K_ACT = 8'h80;
   localparam logic [7:0] K_RD  = 8'h40;
   localparam logic [7:0] K_WR  = 8'h20;
   localparam logic [7:0] K_RDA = 8'h10;
   localparam logic [7:0] K_WRA = 8'h08;
   localparam logic [7:0] K_PR  = 8'h04;
   localparam logic [7:0] K_PRA = 8'h02;
   localparam logic [7:0] K_REF = 8'h01;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_bank = '0;
   logic [13:0] req_row = '0;
   logic [9:0]  req_col = '0;
   logic        ACT, RD, WR, RDA, WRA, PR, PRA, REF;
   logic [1:0]  cmd_bank;
   logic [13:0] cmd_addr;
   logic        done, busy;

   ddr_cmd_issuer #(.TREFI(T_REFI)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_bank  (req_bank),
      .req_row   (req_row),
      .req_col   (req_col),
      .ACT       (ACT),
      .RD        (RD),
      .WR        (WR),
      .RDA       (RDA),
      .WRA       (WRA),
      .PR        (PR),
      .PRA       (PRA),
      .REF       (REF),
      .cmd_bank  (cmd_bank),
      .cmd_addr  (cmd_addr),
      .done      (done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Model state
   logic [31:0] exp_cmd [int];
   bit          exp_done [int];
   int          idle_at = 0;
   int          pend_clr_at = -1;
   int          rst_last = 0;
   bit          pend = 1'b0;
   bit          open_m [4];
   int          row_m [4];
   bit          acc = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
      end
   endtask

   function automatic void put(input int at, input logic [7:0] k, input int b, input int a);
      exp_cmd[at] = {k, 8'(b), 16'(a)};
   endfunction

   // One cycle of the reference model: compare, then schedule new work
   task automatic model_step();
      logic [31:0] ecmd, ocmd;
      logic [7:0]  ccmd;
      bit          idle;
      int          b, r, t, k, d, f, since;
      acc = 1'b0;
      if (cyc == pend_clr_at) pend = 1'b0;
      since = cyc - rst_last - 1;
      if (since >= T_REFI && (since % T_REFI) == 0) pend = 1'b1;

      ecmd = exp_cmd.exists(cyc) ? exp_cmd[cyc] : 32'h0;
      ocmd = {ACT, RD, WR, RDA, WRA, PR, PRA, REF, 8'(cmd_bank), 16'(cmd_addr)};
      idle = (cyc >= idle_at);
      check("cmd", ocmd, ecmd);
      check("done", 32'(done), 32'(exp_done.exists(cyc)));
      check("req_ready", 32'(req_ready), 32'(idle && !pend && !rst));
      check("busy", 32'(busy), 32'(!idle));

      if (rst) begin
         exp_cmd.delete();
         exp_done.delete();
         idle_at     = cyc + 1;
         pend        = 1'b0;
         pend_clr_at = -1;
         rst_last    = cyc;
         foreach (open_m[i]) open_m[i] = 1'b0;
      end else if (idle && pend) begin
         if (open_m[0] || open_m[1] || open_m[2] || open_m[3]) begin
            put(cyc + 1, K_PRA, 0, 0);
            f = cyc + 1 + T_RP;
         end else begin
            f = cyc + 1;
         end
         foreach (open_m[i]) open_m[i] = 1'b0;
         put(f, K_REF, 0, 0);
         idle_at     = f + T_RFC;
         pend_clr_at = f + T_RFC;
      end else if (idle && req_valid) begin
         acc = 1'b1;
         b = int'(req_bank);
         r = int'(req_row);
         t = cyc + 1;
         if (CLOSED || !open_m[b]) begin
            put(t, K_ACT, b, r);
            open_m[b] = 1'b1;
            row_m[b]  = r;
            k = t + T_RCD;
         end else if (row_m[b] == r) begin
            k = t;
         end else begin
            put(t, K_PR, b, 0);
            put(t + T_RP, K_ACT, b, r);
            row_m[b] = r;
            k = t + T_RP + T_RCD;
         end
         if (req_write) ccmd = CLOSED ? K_WRA : K_WR;
         else           ccmd = CLOSED ? K_RDA : K_RD;
         put(k, ccmd, b, int'(req_col));
         d = k + T_CL;
         exp_done[d] = 1'b1;
         if (CLOSED) begin
            open_m[b] = 1'b0;
            idle_at   = d + 1 + T_RP;
         end else begin
            idle_at = d + 1;
         end
      end
   endtask

   task automatic do_cycle();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic issue(input bit w, input int b, input int r, input int col);
      int n;
      req_valid = 1'b1;
      req_write = w;
      req_bank  = 2'(b);
      req_row   = 14'(r);
      req_col   = 10'(col);
      n = 0;
      do_cycle();
      while (!acc && n < 1000) begin
         do_cycle();
         n++;
      end
      check("accept_timeout", 32'(acc), 32'd1);
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_bank  = 2'($urandom);
      req_row   = 14'($urandom);
      req_col   = 10'($urandom);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(cyc >= idle_at && !pend) && n < 2000) begin
         do_cycle();
         n++;
      end
      check("idle_timeout", 32'(n < 2000), 32'd1);
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      repeat (3) do_cycle();
      rst = 1'b0;

      // Closed bank, then row hit, then row miss with a write
      issue(1'b0, 0, 5, 3);
      wait_idle();
      issue(1'b0, 0, 5, 3);
      wait_idle();
      issue(1'b1, 0, 9, 7);
      wait_idle();

      // Open bank 1 and sit idle across a refresh expiry
      issue(1'b0, 1, 11, 2);
      wait_idle();
      repeat (450) do_cycle();
      issue(1'b0, 1, 11, 2);
      wait_idle();

      // Reset in the middle of ACT_WAIT, then the same request again
      issue(1'b0, 2, 4, 1);
      repeat (5) do_cycle();
      rst = 1'b1;
      do_cycle();
      rst = 1'b0;
      issue(1'b0, 2, 4, 1);
      wait_idle();

      // Random traffic over few rows so hits, misses and closed banks all occur
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) do_cycle();
         issue(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 1023)));
      end
      wait_idle();
      repeat (30) do_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ddr_cmd_issuer.md
Name: ddr_cmd_issuer

Overview:
- Controller-side command initiator for the emulated DDR bank timing model.
- Accepts read/write requests over a valid/ready handshake and tracks the open row per bank.
- Issues one-cycle ACT/RD/WR/PR/PRA/REF pulses spaced by the tRCD, tCL, tRP and tRFC counts the bank model enforces.
- Schedules periodic refresh; drives the bank-side FSM inputs directly.

Parameters:
- NBANKS, 4, number of banks (power of 2); BW = $clog2(NBANKS).
- ROWW, 14, row address width.
- COLW, 10, column address width (COLW <= ROWW).
- TRCD, 22, cycles from ACT to RD/WR.
- TCL, 14, cycles from RD/WR to done pulse.
- TRP, 20, cycles from PR/PRA to the next ACT/REF.
- TRFC, 243, cycles from REF to the next command.
- TREFI, 7800, refresh interval in cycles.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready
- req_write  in  1  1=write, 0=read
- req_bank  in  BW  target bank
- req_row  in  ROWW  target row
- req_col  in  COLW  target column
- ACT, RD, WR, RDA, WRA, PR, PRA, REF  out  1 each  one-cycle command pulses
- cmd_bank  out  BW  bank for the current command
- cmd_addr  out  ROWW  row for ACT; column zero-extended for RD/WR; 0 otherwise
- done  out  1  pulse TCL cycles after the column command
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset:
  - All command outputs, done, cmd_bank and cmd_addr are 0; busy=0; req_ready=0 during the reset cycle.
  - Open flags cleared; refresh counter loaded with TREFI; ref_pending=0.
  - Any in-flight request is dropped.
- States: IDLE, ACT_WAIT, CAS_WAIT, PRE_WAIT, REF_PRE_WAIT, REF_WAIT.
- req_ready = (state==IDLE) && !ref_pending && !rst. The request is latched on accept.
- All outputs are registered. The first command appears in the cycle after accept (cycle t).
- Row hit (bank open, same row):
  - RD/WR at t; go to CAS_WAIT.
- Bank closed:
  - ACT at t; go to ACT_WAIT.
  - RD/WR at t+TRCD; go to CAS_WAIT.
- Row miss (bank open, different row):
  - PR at t; go to PRE_WAIT.
  - ACT at t+TRP, then RD/WR at t+TRP+TRCD.
- CAS_WAIT: done pulses TCL cycles after the RD/WR pulse, in the same cycle the FSM returns to IDLE. req_ready is high the following cycle.
- Every wait uses one 8-bit down-counter, loaded with the parameter on command issue and decremented each cycle. The transition happens on the count==1 cycle, so the next command lands exactly T cycles later. Parameters above 255 are illegal, except TREFI, which has its own 16-bit counter.
- Open-table update: ACT sets open[bank] and row[bank]; PR clears open[bank]; PRA clears all.
- Refresh:
  - The refresh counter decrements every cycle. At 1 it sets ref_pending and reloads TREFI.
  - A second expiry while pending is dropped (single bit).
  - In IDLE with ref_pending:
    - If any bank is open: PRA, wait TRP (REF_PRE_WAIT), then REF.
    - Otherwise: REF immediately.
  - After REF, wait TRFC (REF_WAIT), clear ref_pending, return to IDLE.
- Simultaneous events:
  - Expiry in the same cycle as an accept: the request completes first, then the refresh runs.
  - Refresh has priority over new requests in IDLE.
- At most one command pulse is asserted per cycle. cmd_bank and cmd_addr hold 0 when no command is asserted.

Optional Feature:
- Macro: DDR_CLOSED_PAGE_EN.
- Defined:
  - RDA/WRA are issued instead of RD/WR, and the bank is marked closed at issue.
  - After done, the FSM waits TRP (PRE_WAIT) before IDLE.
  - Every request takes the closed-bank path; row-miss PR never occurs.
- Undefined: open-page policy as above; RDA/WRA are tied 0.

Decomposition:
- Package ddr_ctrl_pkg: state enum, command one-hot encoding constants, default timing constants shared with the bank timing model.
- Sub-module ddr_bank_table: per-bank open flag and row register.
  - Inputs: set, clear, clear_all, bank, row.
  - Combinational outputs: hit, open.

Test Plan:
- Reset, then read bank0 row5 col3 (closed) -> ACT(bank0, addr5) at t, RD(addr3) at t+22, done at t+36, req_ready high at t+37.
- Same request repeated (row hit) -> RD at t, done at t+14, no ACT/PR.
- Write bank0 row9 (miss) -> PR at t, ACT(addr9) at t+20, WR at t+42, done at t+56.
- TREFI=400, bank1 open, idle -> at expiry req_ready drops; PRA, REF 20 cycles later, req_ready high 243 cycles after REF; a subsequent read needs ACT.
- rst asserted during ACT_WAIT -> next cycle all outputs 0, busy=0; the next same-row request issues ACT (table cleared).
- With DDR_CLOSED_PAGE_EN, two reads to the same row -> each is ACT, RDA at +22, done at +36, 20-cycle gap before ready; PR never pulses.
